serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder: the addition counterpart of the combinational one-bit subtractor datapath. It accepts two WIDTH-bit operands and a carry-in on a start pulse, then adds one bit per clock, LSB first, through a single one-bit full-adder cell and a carry flip-flop. It returns the sum and carry-out with a one-cycle done pulse. It sits beside the subtractor blocks as the area-minimal add path for the arithmetic unit.

## Interface
- WIDTH, 2, operand/sum width in bits; legal range 1–16.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend-side operand (addend A), captured on accepted start
- b  input  WIDTH  addend B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: sum/cout valid
- sum  output  WIDTH  result (a + b + cin) mod 2^WIDTH, held until next accepted start
- cout  output  1  carry out of bit WIDTH-1, held with sum

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE:**
  - If start=1, capture a, b and cin into shift registers and the carry FF, clear the bit counter, and go to RUN.
  - If start=0, stay in IDLE.
- **RUN:**
  - Each cycle, the full-adder cell combines the current LSBs of the A and B shift registers with the carry FF.
  - The sum bit shifts into the MSB of the sum register; the sum register shifts right.
  - The carry FF takes the cell's carry-out, the operand registers shift right, and the counter increments.
  - On the edge that processes bit WIDTH-1, go to DONE, load cout from the final carry, and assert done.
- **DONE:**
  - On the next edge, go to IDLE and deassert done.
  - sum and cout keep their values.
- **start handling:**
  - start is ignored in RUN and DONE; it is neither queued nor an error.
  - The input a/b/cin are don't-care outside the accepting edge.
- **Full-adder logic:**
  - sum bit = x ^ y ^ c.
  - carry = (x & y) | (c & (x ^ y)).
  - It is built from the shared basic gate cells.
- **Counter:** width is clog2(WIDTH) with a minimum of 1, and it counts 0..WIDTH-1.
- **Arithmetic:** unsigned, with no overflow flag; cout is the 2^WIDTH bit.

## Timing
- **Reset values:**
  - busy=0, done=0, sum=0, cout=0, state=IDLE.
  - Internal shift registers, carry FF and counter are all 0.
- **Latency:** start is accepted at edge k. busy goes high after edge k, and done goes high after edge k+WIDTH. done returns low after edge k+WIDTH+1, when the FSM is back in IDLE.
- **Throughput:** one operation per WIDTH+2 cycles. The earliest next accept is edge k+WIDTH+2.
- **Output stability:** sum is valid only when done=1 or afterwards; intermediate sum contents during RUN are undefined to consumers.
- **start held high:** after the FSM returns to IDLE, the next edge accepts a new operation with the currently presented operands.
- **Reset mid-operation:** the operation aborts immediately (asynchronously) and all outputs take their reset values. No done is produced for the aborted operation.
- **WIDTH=1:** RUN lasts exactly one cycle.

## Structure
- Sub-module full_adder_bit (inputs x, y, c; outputs s, co) is the single combinational cell, built from the shared xor/and/or gate primitives.
- The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) belong in the shared arithmetic include header, beside the basic gate definitions, so the serial subtractor and other sequenced blocks reuse them.
- The FSM, counter, shift registers and carry FF live in serial_adder.

## Test plan
- **Basic carry-out:** WIDTH=2, a=2'b11, b=2'b01, cin=0, start pulse -> done after 2 cycles, sum=2'b00, cout=1; busy high for exactly 2 cycles.
- **Carry-in propagation:** WIDTH=4, a=4'hF, b=4'h0, cin=1 -> sum=4'h0, cout=1. Then a=4'h5, b=4'h3, cin=0 -> sum=4'h8, cout=0.
- **start ignored while busy:** WIDTH=4, assert start with a=4'h1, b=4'h1; re-pulse start with a=4'hF during RUN -> result is still sum=4'h2, and only one done pulse.
- **Reset mid-operation:** WIDTH=4, drop rst_n in the second RUN cycle -> busy, done, sum and cout go to 0 immediately; after release the FSM is in IDLE and the next op computes 4'h7+4'h9 = sum 4'h0, cout 1.
- **Back-to-back and exhaustive:** hold start=1 continuously with WIDTH=2 -> accepts exactly every 4 cycles. Exhaustive sweep of all a, b, cin for WIDTH=2 matches {cout,sum}=a+b+cin.
- **Single-bit width:** WIDTH=1, a=1, b=1, cin=1 -> done one cycle after accept, sum=1, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module     : serial_adder_pkg
// Description: Shared arithmetic definitions: sequencer state encodings and
//              the basic one-bit gate cells used by the bit-serial datapaths.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  // Sequencer state encodings shared by the serial add/subtract blocks
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Basic gate cells
  function automatic logic gate_xor(input logic x, input logic y);
    return x ^ y;
  endfunction

  function automatic logic gate_and(input logic x, input logic y);
    return x & y;
  endfunction

  function automatic logic gate_or(input logic x, input logic y);
    return x | y;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_fa.sv
// ============================================================================
// Module     : full_adder_bit
// Description: One-bit full-adder cell built from the shared gate cells.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_bit
  import serial_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);

  logic w_xy;

  // Half-sum is reused by both the sum and the propagate term of the carry
  always_comb begin
    w_xy = gate_xor(x, y);
    s    = gate_xor(w_xy, c);
    co   = gate_or(gate_and(x, y), gate_and(c, w_xy));
  end

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module     : serial_adder
// Description: Bit-serial adder. Adds two WIDTH-bit operands plus carry-in,
//              LSB first, one bit per clock through a single full-adder cell.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_shift;

  full_adder_bit u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is at the LSB
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_s;
    end else begin : g_sum_wn
      assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  // Sequencer: accept in IDLE, one bit per cycle in RUN, single-cycle DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = sum_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cout_d  = fa_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module     : tb_serial_adder
// Description: Self-checking bench for serial_adder at WIDTH = 1, 2 and 4.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic       st [3];
  logic [3:0] av [3];
  logic [3:0] bv [3];
  logic       ci [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       cout_w [3];
  logic [3:0] sum_w  [3];

  logic [0:0] sum0;
  logic [1:0] sum1;
  logic [3:0] sum2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state per instance: edges since accept (0 = idle)
  int         t      [3];
  logic [4:0] res    [3];
  logic [3:0] exp_s  [3];
  logic       exp_c  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0][0:0]), .b(bv[0][0:0]),
    .cin(ci[0]), .busy(busy_w[0]), .done(done_w[0]), .sum(sum0), .cout(cout_w[0])
  );
  serial_adder #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][1:0]), .b(bv[1][1:0]),
    .cin(ci[1]), .busy(busy_w[1]), .done(done_w[1]), .sum(sum1), .cout(cout_w[1])
  );
  serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]),
    .cin(ci[2]), .busy(busy_w[2]), .done(done_w[2]), .sum(sum2), .cout(cout_w[2])
  );

  assign sum_w[0] = {3'b000, sum0};
  assign sum_w[1] = {2'b00, sum1};
  assign sum_w[2] = sum2;

  function automatic int wof(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string name, input int i, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s [W=%0d] t=%0t: got %0d, expected %0d", name, wof(i), $time, act, expv);
    end
  endtask

  // Model: an accepted op finishes WIDTH edges later, sum/cout appear with done
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int w;
      w = wof(i);
      if (!rst_n) begin
        t[i] = 0; exp_s[i] = '0; exp_c[i] = 1'b0;
      end else if (t[i] == 0) begin
        if (st[i]) begin
          t[i]   = 1;
          res[i] = 5'((av[i] & 4'((1 << w) - 1)) + (bv[i] & 4'((1 << w) - 1)) + 4'(ci[i]));
        end
      end else if (t[i] <= w) begin
        t[i] = t[i] + 1;
        if (t[i] == w + 1) begin
          exp_s[i] = 4'(res[i] & 5'((1 << w) - 1));
          exp_c[i] = res[i][w];
        end
      end else begin
        t[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      int w;
      w = wof(i);
      chk("busy", i, int'(busy_w[i]), int'(t[i] >= 1 && t[i] <= w));
      chk("done", i, int'(done_w[i]), int'(t[i] == w + 1));
      if (!(t[i] >= 1 && t[i] <= w)) begin
        chk("sum", i, int'(sum_w[i]), int'(exp_s[i]));
        chk("cout", i, int'(cout_w[i]), int'(exp_c[i]));
      end
    end
  end

  // Run one operation and check against literal expectations
  task automatic op(input int i, input logic [3:0] a_, input logic [3:0] b_, input logic c_,
                    input logic [3:0] es, input logic ec);
    int  nbusy;
    bit  seen;
    nbusy = 0;
    seen  = 0;
    @(negedge clk);
    st[i] = 1'b1; av[i] = a_; bv[i] = b_; ci[i] = c_;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      st[i] = 1'b0;
      if (busy_w[i]) nbusy++;
      if (done_w[i]) begin
        seen = 1;
        chk("op_sum", i, int'(sum_w[i]), int'(es));
        chk("op_cout", i, int'(cout_w[i]), int'(ec));
        chk("op_busy_cycles", i, nbusy, wof(i));
      end
    end
    if (!seen) chk("op_timeout", i, 0, 1);
  endtask

  initial begin
    int ndone;
    logic [3:0] es;
    logic [4:0] tot;
    for (int i = 0; i < 3; i++) begin
      st[i] = 0; av[i] = 0; bv[i] = 0; ci[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed cases
    op(1, 4'h3, 4'h1, 1'b0, 4'h0, 1'b1);
    op(2, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1);
    op(2, 4'h5, 4'h3, 1'b0, 4'h8, 1'b0);
    op(0, 4'h1, 4'h1, 1'b1, 4'h1, 1'b1);
    op(0, 4'h1, 4'h0, 1'b0, 4'h1, 1'b0);

    // start re-asserted during RUN is ignored
    @(negedge clk);
    st[2] = 1; av[2] = 4'h1; bv[2] = 4'h1; ci[2] = 0;
    @(negedge clk); st[2] = 0;
    @(negedge clk); st[2] = 1; av[2] = 4'hF;
    @(negedge clk); st[2] = 0; av[2] = 4'h0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_w[2]) begin
        ndone++;
        chk("ignore_sum", 2, int'(sum_w[2]), 2);
      end
    end
    chk("ignore_done_count", 2, ndone, 1);

    // Reset in the second RUN cycle
    @(negedge clk);
    st[2] = 1; av[2] = 4'h6; bv[2] = 4'h6; ci[2] = 0;
    @(negedge clk); st[2] = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 2, int'(busy_w[2]), 0);
    chk("rst_done", 2, int'(done_w[2]), 0);
    chk("rst_sum", 2, int'(sum_w[2]), 0);
    chk("rst_cout", 2, int'(cout_w[2]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op(2, 4'h7, 4'h9, 1'b0, 4'h0, 1'b1);

    // start held high: one accept every WIDTH+2 cycles
    @(negedge clk);
    st[1] = 1; av[1] = 4'h2; bv[1] = 4'h3; ci[1] = 1;
    ndone = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done_w[1]) ndone++;
    end
    st[1] = 0;
    chk("b2b_done_count", 1, ndone, 4);
    repeat (4) @(negedge clk);

    // Exhaustive WIDTH=2
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++) begin
          tot = 5'(x + y + c);
          es  = {2'b00, tot[1:0]};
          op(1, 4'(x), 4'(y), c[0], es, tot[2]);
        end

    // Random traffic on all widths, start and operands toggling freely
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        st[i] = ($urandom_range(0, 2) == 0);
        av[i] = 4'($urandom);
        bv[i] = 4'($urandom);
        ci[i] = 1'($urandom);
      end
    end
    for (int i = 0; i < 3; i++) st[i] = 0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
